// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Bit positions inside fault_code
  localparam int unsigned FAULT_TIMEOUT  = 0;
  localparam int unsigned FAULT_MISALIGN = 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StUpdate,
    StFault
  } fseq_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of imem, execute and PC-control signals around the fetch sequencer.
interface fetch_sequencer_if
  import fetch_seq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic [XLEN-1:0] pc_val;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            exec_done;
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            pc_inc;
  logic            pc_load;
  logic [XLEN-1:0] pc_data;
  logic            pc_disable;
  logic            fault;
  logic [1:0]      fault_code;

  modport master (
    input  pc_val, imem_ack, imem_rdata, exec_done, stall, branch_taken, branch_target,
    output imem_req, imem_addr, instr, instr_valid, pc_inc, pc_load, pc_data, pc_disable,
           fault, fault_code
  );

  modport slave (
    output pc_val, imem_ack, imem_rdata, exec_done, stall, branch_taken, branch_target,
    input  imem_req, imem_addr, instr, instr_valid, pc_inc, pc_load, pc_data, pc_disable,
           fault, fault_code
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts imem wait cycles; expired flags the last cycle allowed before a timeout fault.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic inc,
  output logic expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (start) begin
      // The FETCH cycle already consumed one request cycle
      count_q <= 8'd1;
    end else if (inc) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/PC sequencing FSM for the RV32I core with sticky imem-timeout fault.
// Define FETCH_SEQ_MISALIGN_CHK_EN to fault on misaligned taken branch targets.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned TIMEOUT = 16
) (
  input logic          clk,
  input logic          clr,
  fetch_sequencer_if.master bus
);

  fseq_state_t     state_q;
  logic            imem_req_q;
  logic [XLEN-1:0] imem_addr_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic            pc_inc_q;
  logic            pc_load_q;
  logic [XLEN-1:0] pc_data_q;
  logic            pc_disable_q;
  logic            fault_q;
  logic [1:0]      fault_code_q;

  logic tmo_start;
  logic tmo_inc;
  logic tmo_expired;
  logic exec_go;

  assign tmo_start = (state_q == StFetch) && !bus.imem_ack;
  assign tmo_inc   = (state_q == StWait) && !bus.imem_ack && !tmo_expired;
  assign exec_go   = bus.exec_done && !bus.stall;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .clr     (clr),
    .start   (tmo_start),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StIdle;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_data_q     <= '0;
      pc_disable_q  <= 1'b1;
      fault_q       <= 1'b0;
      fault_code_q  <= 2'b00;
    end else begin
      pc_inc_q  <= 1'b0;
      pc_load_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!bus.stall) begin
            state_q     <= StFetch;
            imem_req_q  <= 1'b1;
            imem_addr_q <= bus.pc_val;
          end
        end
        StFetch, StWait: begin
          if (bus.imem_ack) begin
            state_q       <= StExec;
            instr_q       <= bus.imem_rdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else if (state_q == StFetch) begin
            state_q <= StWait;
          end else if (tmo_expired) begin
            state_q                     <= StFault;
            imem_req_q                  <= 1'b0;
            fault_q                     <= 1'b1;
            fault_code_q[FAULT_TIMEOUT] <= 1'b1;
          end
        end
        StExec: begin
          if (exec_go) begin
            instr_valid_q <= 1'b0;
`ifdef FETCH_SEQ_MISALIGN_CHK_EN
            if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
              state_q                      <= StFault;
              fault_q                      <= 1'b1;
              fault_code_q[FAULT_MISALIGN] <= 1'b1;
            end else begin
              state_q      <= StUpdate;
              pc_disable_q <= 1'b0;
              pc_load_q    <= bus.branch_taken;
              pc_inc_q     <= !bus.branch_taken;
              if (bus.branch_taken) begin
                pc_data_q <= bus.branch_target;
              end
            end
`else
            state_q      <= StUpdate;
            pc_disable_q <= 1'b0;
            pc_load_q    <= bus.branch_taken;
            pc_inc_q     <= !bus.branch_taken;
            if (bus.branch_taken) begin
              pc_data_q <= bus.branch_target & ~XLEN'(3);
            end
`endif
          end
        end
        StUpdate: begin
          state_q      <= StFetch;
          pc_disable_q <= 1'b1;
          imem_req_q   <= 1'b1;
          imem_addr_q  <= bus.pc_val;
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_data     = pc_data_q;
  assign bus.pc_disable  = pc_disable_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scenario tasks plus randomized instruction stream.
module tb_fetch_sequencer;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic clr;
  int checks = 0;
  int errors = 0;
  logic [31:0] pc_model;

  fetch_sequencer_if #(.XLEN(XLEN)) bus ();

  fetch_sequencer #(
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {imem_req, instr_valid, pc_inc, pc_load, pc_disable, fault}
  function automatic logic [5:0] obs_ctl();
    return {bus.imem_req, bus.instr_valid, bus.pc_inc, bus.pc_load, bus.pc_disable, bus.fault};
  endfunction

  task automatic enter_fetch();
    bus.pc_val = pc_model;
    bus.stall  = 1'b0;
    tick();
  endtask

  // One instruction from the first FETCH cycle to the first cycle of the next FETCH.
  task automatic do_instr(input int w, input logic [31:0] rdata, input int st,
                          input logic taken, input logic [31:0] target);
    logic [31:0] exp_pc;
    for (int i = 0; i <= w; i++) begin
      checks++;
      if (obs_ctl() !== 6'b100010 || bus.imem_addr !== pc_model) begin
        errors++;
        $display("FAIL fetch_req cyc=%0d ctl=%b addr=%h want ctl=100010 addr=%h",
                 i, obs_ctl(), bus.imem_addr, pc_model);
      end
      bus.imem_ack     = (i == w);
      bus.imem_rdata   = (i == w) ? rdata : $urandom;
      bus.exec_done    = 1'($urandom);
      bus.branch_taken = 1'($urandom);
      bus.pc_val       = $urandom;
      tick();
    end
    bus.imem_ack = 1'b0;
    bus.pc_val   = pc_model;
    checks++;
    if (obs_ctl() !== 6'b010010 || bus.instr !== rdata) begin
      errors++;
      $display("FAIL exec_entry ctl=%b instr=%h want ctl=010010 instr=%h",
               obs_ctl(), bus.instr, rdata);
    end
    bus.exec_done     = 1'b1;
    bus.branch_taken  = taken;
    bus.branch_target = target;
    bus.stall         = (st > 0);
    for (int s = 0; s < st; s++) begin
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      tick();
      checks++;
      if (obs_ctl() !== 6'b010010 || bus.instr !== rdata) begin
        errors++;
        $display("FAIL exec_stall cyc=%0d ctl=%b instr=%h want ctl=010010 instr=%h",
                 s, obs_ctl(), bus.instr, rdata);
      end
      if (s == st - 1) bus.stall = 1'b0;
    end
    bus.imem_ack = 1'b0;
    tick();
    bus.exec_done     = 1'b0;
    bus.branch_taken  = 1'($urandom);
    bus.branch_target = $urandom;
    exp_pc = taken ? (target & ~32'h3) : pc_model + 32'd4;
    checks++;
    if (obs_ctl() !== {2'b00, ~taken, taken, 2'b00} ||
        (taken && bus.pc_data !== exp_pc)) begin
      errors++;
      $display("FAIL update ctl=%b pc_data=%h want ctl=%b pc_data=%h",
               obs_ctl(), bus.pc_data, {2'b00, ~taken, taken, 2'b00}, exp_pc);
    end
    pc_model   = exp_pc;
    bus.pc_val = pc_model;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.stall = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_ctl() !== 6'b000010 || bus.imem_addr !== 32'h0 || bus.instr !== 32'h0 ||
        bus.pc_data !== 32'h0 || bus.fault_code !== 2'b00) begin
      errors++;
      $display("FAIL reset ctl=%b addr=%h instr=%h pc_data=%h code=%b want 000010 and zeros",
               obs_ctl(), bus.imem_addr, bus.instr, bus.pc_data, bus.fault_code);
    end
    clr = 1'b0;
    tick();
    checks++;
    if (obs_ctl() !== 6'b000010) begin
      errors++;
      $display("FAIL idle_stall ctl=%b want 000010", obs_ctl());
    end
  endtask

  task automatic test_basic();
    pc_model = 32'h0;
    enter_fetch();
    for (int k = 0; k < 4; k++) do_instr(0, $urandom, 0, 1'b0, 32'h0);
  endtask

  task automatic test_wait();
    do_instr(3, 32'h0050_0093, 0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    do_instr(0, $urandom, 0, 1'b1, 32'h20);
    do_instr(0, $urandom, 0, 1'b0, 32'h0);
  endtask

  task automatic test_stall();
    do_instr(0, $urandom, 5, 1'b0, 32'h0);
  endtask

  task automatic test_misalign();
`ifdef FETCH_SEQ_MISALIGN_CHK_EN
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    tick();
    bus.imem_ack      = 1'b0;
    bus.exec_done     = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h22;
    tick();
    bus.exec_done = 1'b0;
    checks++;
    if (obs_ctl() !== 6'b000011 || bus.fault_code !== 2'b10) begin
      errors++;
      $display("FAIL misalign ctl=%b code=%b want ctl=000011 code=10", obs_ctl(), bus.fault_code);
    end
    clr = 1'b1;
    bus.stall = 1'b1;
    tick();
    clr = 1'b0;
    enter_fetch();
`else
    do_instr(0, $urandom, 0, 1'b1, 32'h22);
    checks++;
    if (bus.fault_code !== 2'b00) begin
      errors++;
      $display("FAIL misalign_code code=%b want 00", bus.fault_code);
    end
`endif
  endtask

  task automatic test_clr_mid_wait();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    bus.stall = 1'b1;
    tick();
    checks++;
    if (obs_ctl() !== 6'b000010 || bus.imem_addr !== 32'h0 || bus.instr !== 32'h0) begin
      errors++;
      $display("FAIL clr_wait ctl=%b addr=%h instr=%h want ctl=000010 addr=0 instr=0",
               obs_ctl(), bus.imem_addr, bus.instr);
    end
    clr = 1'b0;
    tick();
    enter_fetch();
    // Ack on the last request cycle before a timeout would fire
    do_instr(TIMEOUT - 1, $urandom, 0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int n = 0; n < 20; n++) begin
      tgt = $urandom;
`ifdef FETCH_SEQ_MISALIGN_CHK_EN
      tgt[1:0] = 2'b00;
`endif
      do_instr(int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)),
               1'($urandom), tgt);
    end
  endtask

  task automatic test_timeout();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      checks++;
      if (obs_ctl() !== 6'b100010 || bus.imem_addr !== pc_model) begin
        errors++;
        $display("FAIL timeout_req cyc=%0d ctl=%b addr=%h want ctl=100010 addr=%h",
                 i, obs_ctl(), bus.imem_addr, pc_model);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_ctl() !== 6'b000011 || bus.fault_code !== 2'b01) begin
        errors++;
        $display("FAIL timeout_fault cyc=%0d ctl=%b code=%b want ctl=000011 code=01",
                 i, obs_ctl(), bus.fault_code);
      end
      bus.imem_ack = 1'($urandom);
      bus.stall    = 1'($urandom);
      tick();
    end
    bus.imem_ack = 1'b0;
    clr = 1'b1;
    bus.stall = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (obs_ctl() !== 6'b000010 || bus.fault_code !== 2'b00 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL timeout_clr ctl=%b code=%b addr=%h want ctl=000010 code=00 addr=0",
               obs_ctl(), bus.fault_code, bus.imem_addr);
    end
  endtask

  initial begin
    clr               = 1'b1;
    pc_model          = 32'h0;
    bus.pc_val        = 32'h0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.exec_done     = 1'b0;
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    test_reset();
    test_basic();
    test_wait();
    test_branch();
    test_stall();
    test_misalign();
    test_clr_mid_wait();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
